reg_decoder_scan: RTL and testbench
===================================

REG_DECODER_SCAN -- requirements
Module: reg_decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2, SHALL set the select width; legal range 1..6.
REQ-002 Parameter SCAN_DIV, default 4, SHALL set the clock cycles per scan step; legal range 1..255.
REQ-003 Localparam OUT_W SHALL equal 2**SEL_W and set the output width.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  SHALL be the reset, asynchronous and active-low.
REQ-006 e  in  1  SHALL be the synchronous enable; 0 blanks outputs.
REQ-007 ld  in  1  SHALL be the load strobe; it captures sel and mode.
REQ-008 mode  in  2  SHALL be the operating mode: 00 DECODE, 01 THERM, 10 SCAN, 11 FREEZE.
REQ-009 sel  in  SEL_W  SHALL be the select or start index.
REQ-010 d  out  OUT_W  SHALL be the registered decoded output.
REQ-011 busy  out  1  SHALL be high while in state SCAN.
REQ-012 wrap  out  1  SHALL be a one-cycle pulse on scan wrap-around.

Function
REQ-013 States: IDLE, DEC, THERM, SCAN, FRZ; all transitions occur on the clk rising edge.
REQ-014 Priority: e=0 over ld over hold.
REQ-015 e=0: next cycle d=0, state=IDLE, index=0, prescaler=0, wrap=0; ld ignored.
REQ-016 e=1, ld=1: sel latched into index; prescaler cleared; next state per mode (00 DEC, 01 THERM, 10 SCAN, 11 FRZ).
REQ-017 Latency ld to d SHALL be exactly 1 cycle.
REQ-018 DEC: d = one-hot, bit[index]=1, all others 0; held until next ld or e=0.
REQ-019 THERM: d[i]=1 for all i<=index, else 0; index=OUT_W-1 gives all ones.
REQ-020 SCAN, first cycle: d = one-hot(index).
REQ-021 SCAN prescaler: counts 0..SCAN_DIV-1; on terminal count index increments by 1 and d updates on the same edge.
REQ-022 SCAN_DIV=1: index advances every cycle.
REQ-023 Wrap: index increments modulo OUT_W; step OUT_W-1 to 0 asserts wrap for exactly the cycle d=one-hot(0).
REQ-024 ld=1 with no step pending: wrap=0.
REQ-025 FRZ: d retains its value from the cycle before entry; index and prescaler frozen; busy=0.
REQ-026 ld during SCAN: restarts from new sel with prescaler=0; any pending step is discarded.
REQ-027 ld coinciding with a terminal count: the load wins and wrap=0.
REQ-028 IDLE: d=0, busy=0, wrap=0.
REQ-029 Outputs SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-030 rst_n=0: immediately, independent of clk, d=0, busy=0, wrap=0, state=IDLE, index=0, prescaler=0.
REQ-031 Reset mid-scan SHALL abort the scan with no wrap pulse.
REQ-032 After deassertion, the first ld with e=1 SHALL behave per REQ-016.
REQ-033 rst_n SHALL be deasserted synchronously to clk outside this block.

Verification (SEL_W=2, SCAN_DIV=4)
REQ-034 DEC sweep: e=1, ld pulse, mode=00, sel=0..3 -> d=0001, 0010, 0100, 1000 one cycle after each ld; busy=0.
REQ-035 THERM: ld, mode=01, sel=2 -> d=0111; sel=3 -> 1111; sel=0 -> 0001.
REQ-036 SCAN wrap: ld, mode=10, sel=2 -> d=0100 for 4 cycles, 1000 for 4, then 0001 with wrap=1 for 1 cycle; busy=1 throughout.
REQ-037 Enable blank: in SCAN set e=0 together with ld=1 -> next cycle d=0000, busy=0, state IDLE.
REQ-038 Freeze and async reset: in SCAN at d=1000, ld with mode=11 -> d stays 1000 for 10+ cycles, busy=0. Then rst_n low mid-cycle -> d=0000 before the next edge, wrap never asserted.
REQ-039 Restart: in SCAN, ld sel=1 on the cycle of a terminal count -> d=0010 next cycle, wrap=0, next step 4 cycles later.

Source files
------------

// File: rtl/reg_decoder_scan.sv
// reg_decoder_scan: registered select decoder with one-hot, thermometer, scanning and freeze modes
//   clk   : single clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   e     : synchronous enable; 0 blanks outputs and returns to IDLE
//   ld    : load strobe; captures sel and mode
//   mode  : 00 DECODE, 01 THERM, 10 SCAN, 11 FREEZE
//   sel   : select / scan start index
//   d     : registered decoded output (2**SEL_W bits)
//   busy  : high while scanning
//   wrap  : one-cycle pulse when the scan index wraps to 0
module reg_decoder_scan #(
    parameter int SEL_W = 2,
    parameter int SCAN_DIV = 4,
    localparam int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic             ld,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] d,
    output logic             busy,
    output logic             wrap
);
    typedef enum logic [2:0] {IDLE, DEC, THERM, SCAN, FRZ} state_t;
    localparam logic [7:0] TC = 8'(SCAN_DIV - 1);
    state_t             st, st_nx;
    logic [SEL_W-1:0]   idx, idx_nx;
    logic [7:0]         pre, pre_nx;
    logic [OUT_W-1:0]   d_nx;
    logic               wrap_nx;
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
        return OUT_W'(1) << i;
    endfunction
    function automatic logic [OUT_W-1:0] therm(input logic [SEL_W-1:0] i);
        return {OUT_W{1'b1}} >> (OUT_W - 1 - int'(i));
    endfunction
    always_comb begin
        st_nx   = st;
        idx_nx  = idx;
        pre_nx  = pre;
        d_nx    = d;
        wrap_nx = 1'b0;
        if (!e) begin
            st_nx  = IDLE;
            idx_nx = '0;
            pre_nx = '0;
            d_nx   = '0;
        end else if (ld) begin
            // a load always restarts cleanly, discarding any pending scan step
            idx_nx = sel;
            pre_nx = '0;
            st_nx  = mode == 2'b00 ? DEC : mode == 2'b01 ? THERM : mode == 2'b10 ? SCAN : FRZ;
            d_nx   = mode == 2'b01 ? therm(sel) : mode == 2'b11 ? d : onehot(sel);
        end else if (st == SCAN) begin
            if (pre == TC) begin
                pre_nx  = '0;
                idx_nx  = idx + 1'b1;
                d_nx    = onehot(idx + 1'b1);
                wrap_nx = &idx;
            end else begin
                pre_nx = pre + 8'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st   <= IDLE;
            idx  <= '0;
            pre  <= '0;
            d    <= '0;
            busy <= 1'b0;
            wrap <= 1'b0;
        end else begin
            st   <= st_nx;
            idx  <= idx_nx;
            pre  <= pre_nx;
            d    <= d_nx;
            busy <= st_nx == SCAN;
            wrap <= wrap_nx;
        end
    end
endmodule

// File: tb/tb_reg_decoder_scan.sv
// tb_reg_decoder_scan: directed and random checks of reg_decoder_scan against a behavioural model
//   Drives e/ld/mode/sel each cycle, predicts d/busy/wrap, compares 1 time unit after each edge.
module tb_reg_decoder_scan;
    localparam int N = 4;
    localparam int DIV = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       e = 1'b0;
    logic       ld = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] sel = 2'b00;
    logic [3:0] d;
    logic       busy;
    logic       wrap;
    int n_cmp = 0;
    int n_bad = 0;
    // reference model: active flag, loaded mode, index, step counter, held output
    bit         m_on;
    int         m_mode, m_idx, m_cnt;
    logic [3:0] m_d;
    bit         m_wrap;
    reg_decoder_scan #(.SEL_W(2), .SCAN_DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .e(e), .ld(ld), .mode(mode), .sel(sel),
        .d(d), .busy(busy), .wrap(wrap)
    );
    always #5 clk = ~clk;
    task automatic model_reset();
        m_on = 0; m_mode = 0; m_idx = 0; m_cnt = 0; m_d = 4'b0000; m_wrap = 0;
    endtask
    task automatic model_step(input bit ie, input bit ild, input int imode, input int isel);
        m_wrap = 0;
        if (!ie) begin
            model_reset();
        end else if (ild) begin
            m_on = 1; m_mode = imode; m_idx = isel; m_cnt = 0;
            if (imode == 0 || imode == 2) m_d = 4'(1 << isel);
            else if (imode == 1) m_d = 4'((1 << (isel + 1)) - 1);
        end else if (m_on && m_mode == 2) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % N;
                m_d = 4'(1 << m_idx);
                m_wrap = (m_idx == 0);
            end
        end
    endtask
    task automatic check(input string tag);
        logic exp_busy;
        exp_busy = m_on && m_mode == 2;
        n_cmp++;
        assert (d === m_d) else begin n_bad++; $error("FAIL %s d got %b exp %b", tag, d, m_d); end
        n_cmp++;
        assert (busy === exp_busy) else begin n_bad++; $error("FAIL %s busy got %b exp %b", tag, busy, exp_busy); end
        n_cmp++;
        assert (wrap === m_wrap) else begin n_bad++; $error("FAIL %s wrap got %b exp %b", tag, wrap, m_wrap); end
    endtask
    task automatic step(input bit ie, input bit ild, input int imode, input int isel, input string tag);
        e = ie; ld = ild; mode = 2'(imode); sel = 2'(isel);
        @(posedge clk);
        model_step(ie, ild, imode, isel);
        #1;
        check(tag);
    endtask
    initial begin
        model_reset();
        #3 check("reset_async");
        repeat (2) @(posedge clk);
        #1 check("reset_held");
        #4 rst_n = 1'b1;
        step(0, 0, 0, 0, "idle");
        step(1, 0, 0, 0, "idle_hold");
        for (int s = 0; s < 4; s++) step(1, 1, 0, s, "dec_sweep");
        step(1, 0, 0, 0, "dec_hold");
        step(1, 1, 1, 2, "therm2");
        step(1, 1, 1, 3, "therm3");
        step(1, 1, 1, 0, "therm0");
        step(1, 1, 2, 2, "scan_start");
        for (int i = 0; i < 12; i++) step(1, 0, 0, 0, "scan_wrap");
        step(0, 1, 2, 1, "enable_blank");
        step(1, 0, 0, 0, "blank_hold");
        step(1, 1, 2, 0, "restart_start");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "restart_pre");
        step(1, 1, 2, 1, "restart_ld_tc");
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, "restart_after");
        step(1, 1, 2, 2, "frz_scan");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, "frz_pre");
        step(1, 1, 3, 0, "frz_enter");
        for (int i = 0; i < 11; i++) step(1, 0, 0, 0, "frz_hold");
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("async_reset_midcycle");
        step(1, 0, 0, 0, "reset_during");
        @(negedge clk) rst_n = 1'b1;
        step(1, 1, 0, 3, "post_reset_ld");
        step(1, 1, 3, 1, "frz_from_dec");
        step(1, 0, 0, 0, "frz_from_dec_hold");
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
